// File: rtl/axis_probe_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream probe among NUM_REQ requesters.
// A grant spans one stimulus packet plus its response packet; re-arbitration waits for the response tlast.
module axis_probe_arbiter #(
  parameter int  C_DATA_WIDTH = 128,
  parameter int  NUM_REQ      = 2,
  localparam int KW           = C_DATA_WIDTH / 8,
  localparam int GW           = $clog2(NUM_REQ)
) (
  input  logic                            s_axis_aclk,
  input  logic                            s_axis_aresetn,
  input  logic [NUM_REQ-1:0]              req_tvalid,
  output logic [NUM_REQ-1:0]              req_tready,
  input  logic [NUM_REQ-1:0]              req_tlast,
  input  logic [NUM_REQ*C_DATA_WIDTH-1:0] req_tdata,
  input  logic [NUM_REQ*KW-1:0]           req_tkeep,
  output logic [NUM_REQ-1:0]              rsp_tvalid,
  input  logic [NUM_REQ-1:0]              rsp_tready,
  output logic [C_DATA_WIDTH-1:0]         rsp_tdata,
  output logic [KW-1:0]                   rsp_tkeep,
  output logic                            rsp_tlast,
  output logic                            prb_s_tvalid,
  output logic [C_DATA_WIDTH-1:0]         prb_s_tdata,
  output logic [KW-1:0]                   prb_s_tkeep,
  output logic                            prb_s_tlast,
  input  logic                            prb_s_tready,
  input  logic                            prb_m_tvalid,
  input  logic [C_DATA_WIDTH-1:0]         prb_m_tdata,
  input  logic [KW-1:0]                   prb_m_tkeep,
  input  logic                            prb_m_tlast,
  output logic                            prb_m_tready,
  output logic [GW-1:0]                   grant_id,
  output logic                            busy,
  output logic [31:0]                     txn_cnt,
  output logic                            rsp_unexpected
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  // Requester 0 wins the first arbitration after reset.
  localparam logic [GW-1:0] LAST_GRANT_RST = GW'(NUM_REQ - 1);

  state_e        state_q, state_d;
  logic [GW-1:0] last_grant_q, last_grant_d;
  logic [GW-1:0] grant_id_q, grant_id_d;
  logic          busy_q, busy_d;
  logic [31:0]   txn_cnt_q, txn_cnt_d;
  logic          rsp_unexpected_q, rsp_unexpected_d;
  logic          stim_done_s;
  logic          rsp_done_s;

  function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                            input logic [GW-1:0]      last);
    logic [GW-1:0] pick;
    logic          found;
    logic [GW:0]   idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = {1'b0, last} + (GW+1)'(k);
      if (idx >= (GW+1)'(NUM_REQ)) begin
        idx = idx - (GW+1)'(NUM_REQ);
      end else begin
        idx = idx;
      end
      if (!found && vld[idx[GW-1:0]]) begin
        pick  = idx[GW-1:0];
        found = 1'b1;
      end else begin
        pick  = pick;
      end
    end
    return pick;
  endfunction

  // Route the granted requester onto the probe and the probe response back to it.
  always_comb begin
    req_tready   = {NUM_REQ{1'b0}};
    rsp_tvalid   = {NUM_REQ{1'b0}};
    prb_s_tvalid = 1'b0;
    prb_m_tready = 1'b0;
    prb_s_tdata  = req_tdata[grant_id_q*C_DATA_WIDTH +: C_DATA_WIDTH];
    prb_s_tkeep  = req_tkeep[grant_id_q*KW +: KW];
    prb_s_tlast  = req_tlast[grant_id_q];
    rsp_tdata    = prb_m_tdata;
    rsp_tkeep    = prb_m_tkeep;
    rsp_tlast    = prb_m_tlast;
    case (state_q)
      ST_REQ: begin
        prb_s_tvalid           = req_tvalid[grant_id_q];
        req_tready[grant_id_q] = prb_s_tready;
      end
      ST_RSP: begin
        rsp_tvalid[grant_id_q] = prb_m_tvalid;
        prb_m_tready           = rsp_tready[grant_id_q];
      end
      default: begin
        prb_s_tvalid = 1'b0;
        prb_m_tready = 1'b0;
      end
    endcase
  end

  assign stim_done_s = prb_s_tvalid & prb_s_tready & prb_s_tlast;
  assign rsp_done_s  = prb_m_tvalid & prb_m_tready & prb_m_tlast;

  // Exchange sequencing, grant bookkeeping and the stray-response flag.
  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    grant_id_d       = grant_id_q;
    busy_d           = busy_q;
    txn_cnt_d        = txn_cnt_q;
    rsp_unexpected_d = rsp_unexpected_q;
    if (prb_m_tvalid && (state_q != ST_RSP)) begin
      rsp_unexpected_d = 1'b1;
    end else begin
      rsp_unexpected_d = rsp_unexpected_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (|req_tvalid) begin
          grant_id_d = rr_pick(req_tvalid, last_grant_q);
          state_d    = ST_REQ;
          busy_d     = 1'b1;
        end else begin
          busy_d     = 1'b0;
        end
      end
      ST_REQ: begin
        if (stim_done_s) begin
          state_d = ST_RSP;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_RSP: begin
        if (rsp_done_s) begin
          state_d      = ST_IDLE;
          busy_d       = 1'b0;
          last_grant_d = grant_id_q;
          txn_cnt_d    = txn_cnt_q + 32'd1;
        end else begin
          state_d      = ST_RSP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; an asynchronous reset abandons any partial exchange.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q          <= ST_IDLE;
      last_grant_q     <= LAST_GRANT_RST;
      grant_id_q       <= {GW{1'b0}};
      busy_q           <= 1'b0;
      txn_cnt_q        <= 32'd0;
      rsp_unexpected_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      last_grant_q     <= last_grant_d;
      grant_id_q       <= grant_id_d;
      busy_q           <= busy_d;
      txn_cnt_q        <= txn_cnt_d;
      rsp_unexpected_q <= rsp_unexpected_d;
    end
  end

  assign grant_id       = grant_id_q;
  assign busy           = busy_q;
  assign txn_cnt        = txn_cnt_q;
  assign rsp_unexpected = rsp_unexpected_q;

endmodule

// File: tb/tb_axis_probe_arbiter.sv
// Randomised bench for axis_probe_arbiter: exchange-level reference model checked every cycle,
// plus directed scenarios pinned with hand-computed expectations.
module tb_axis_probe_arbiter;
  localparam int DW = 128;
  localparam int N  = 2;
  localparam int KW = DW / 8;
  localparam int GW = $clog2(N);
  localparam int CW = 128;
  localparam int PH_IDLE = 0;
  localparam int PH_STIM = 1;
  localparam int PH_RSP  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0]    req_tvalid = '0, req_tlast = '0, rsp_tready = '0;
  logic [N-1:0]    req_tready, rsp_tvalid;
  logic [N*DW-1:0] req_tdata = '0;
  logic [N*KW-1:0] req_tkeep = '0;
  logic [DW-1:0]   rsp_tdata, prb_s_tdata;
  logic [KW-1:0]   rsp_tkeep, prb_s_tkeep;
  logic            rsp_tlast, prb_s_tvalid, prb_s_tlast, prb_m_tready;
  logic            prb_s_tready = 1'b0, prb_m_tvalid = 1'b0, prb_m_tlast = 1'b0;
  logic [DW-1:0]   prb_m_tdata = '0;
  logic [KW-1:0]   prb_m_tkeep = '0;
  logic [GW-1:0]   grant_id;
  logic            busy, rsp_unexpected;
  logic [31:0]     txn_cnt;

  axis_probe_arbiter #(.C_DATA_WIDTH(DW), .NUM_REQ(N)) dut (
    .s_axis_aclk(clk), .s_axis_aresetn(rst_n),
    .req_tvalid(req_tvalid), .req_tready(req_tready), .req_tlast(req_tlast),
    .req_tdata(req_tdata), .req_tkeep(req_tkeep),
    .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready),
    .rsp_tdata(rsp_tdata), .rsp_tkeep(rsp_tkeep), .rsp_tlast(rsp_tlast),
    .prb_s_tvalid(prb_s_tvalid), .prb_s_tdata(prb_s_tdata), .prb_s_tkeep(prb_s_tkeep),
    .prb_s_tlast(prb_s_tlast), .prb_s_tready(prb_s_tready),
    .prb_m_tvalid(prb_m_tvalid), .prb_m_tdata(prb_m_tdata), .prb_m_tkeep(prb_m_tkeep),
    .prb_m_tlast(prb_m_tlast), .prb_m_tready(prb_m_tready),
    .grant_id(grant_id), .busy(busy), .txn_cnt(txn_cnt), .rsp_unexpected(rsp_unexpected)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: which exchange is open and who owns it
  int          m_phase = PH_IDLE;
  int          m_owner = 0;
  int          m_last  = N - 1;
  int          m_gid   = 0;
  logic [31:0] m_cnt   = 32'd0;
  logic        m_flag  = 1'b0;
  int          grant_log[$];
  int          req_beats[N];
  int          rsp_beats[N];
  int          rsp_last_at[N];

  // Traffic knobs and requester/probe bench state
  int r_pkts_left[N];
  int r_len[N];
  int r_beat[N];
  bit r_active[N];
  int fixed_len = 0, rsp_fixed = 0;
  int v_duty = 100, s_rdy_duty = 100, m_rdy_duty = 100, m_v_duty = 100;
  bit p_active = 1'b0;
  int p_len = 0, p_beat = 0;
  bit stray_req = 1'b0;

  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic bit all_quiet();
    for (int i = 0; i < N; i++) begin
      if (r_pkts_left[i] != 0 || r_active[i]) return 1'b0;
    end
    return !p_active && (m_phase == PH_IDLE);
  endfunction

  task automatic wait_done(input string tag, input int max_cyc);
    bit done;
    done = 1'b0;
    for (int n = 0; n < max_cyc && !done; n++) begin
      @(posedge clk); #2;
      done = all_quiet();
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s: exchanges still open after %0d cycles, required all complete", tag, max_cyc);
    end
  endtask

  function automatic int rr_expect(input logic [N-1:0] vld, input int last);
    for (int k = 1; k <= N; k++) begin
      if (vld[(last + k) % N]) return (last + k) % N;
    end
    return last;
  endfunction

  // Compare process: outputs against the model, then advance the model on the coming edge
  initial begin : compare
    logic [N-1:0] exp_req_rdy, exp_rsp_vld;
    logic         exp_s_vld, exp_m_rdy;
    int g;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_phase = PH_IDLE; m_last = N - 1; m_gid = 0; m_cnt = 32'd0; m_flag = 1'b0;
        chk("rst_busy", CW'(busy), CW'(1'b0));
        chk("rst_grant_id", CW'(grant_id), CW'(0));
        chk("rst_txn_cnt", CW'(txn_cnt), CW'(0));
        chk("rst_rsp_unexpected", CW'(rsp_unexpected), CW'(1'b0));
        chk("rst_handshake", CW'({req_tready, rsp_tvalid, prb_s_tvalid, prb_m_tready}), CW'(0));
      end else begin
        g = m_owner;
        chk("busy", CW'(busy), CW'(m_phase != PH_IDLE));
        chk("grant_id", CW'(grant_id), CW'(m_gid));
        chk("txn_cnt", CW'(txn_cnt), CW'(m_cnt));
        chk("rsp_unexpected", CW'(rsp_unexpected), CW'(m_flag));
        chk("rsp_payload", CW'(rsp_tdata), CW'(prb_m_tdata));
        chk("rsp_keep_last", CW'({rsp_tkeep, rsp_tlast}), CW'({prb_m_tkeep, prb_m_tlast}));
        exp_req_rdy = '0; exp_rsp_vld = '0; exp_s_vld = 1'b0; exp_m_rdy = 1'b0;
        if (m_phase == PH_STIM) begin
          exp_s_vld      = req_tvalid[g];
          exp_req_rdy[g] = prb_s_tready;
          chk("prb_s_tdata", CW'(prb_s_tdata), CW'(req_tdata[g*DW +: DW]));
          chk("prb_s_keep_last", CW'({prb_s_tkeep, prb_s_tlast}), CW'({req_tkeep[g*KW +: KW], req_tlast[g]}));
        end
        if (m_phase == PH_RSP) begin
          exp_rsp_vld[g] = prb_m_tvalid;
          exp_m_rdy      = rsp_tready[g];
        end
        chk("req_tready", CW'(req_tready), CW'(exp_req_rdy));
        chk("rsp_tvalid", CW'(rsp_tvalid), CW'(exp_rsp_vld));
        chk("prb_s_tvalid", CW'(prb_s_tvalid), CW'(exp_s_vld));
        chk("prb_m_tready", CW'(prb_m_tready), CW'(exp_m_rdy));
        for (int i = 0; i < N; i++) begin
          if (req_tvalid[i] && req_tready[i]) req_beats[i]++;
          if (rsp_tvalid[i] && rsp_tready[i]) begin
            rsp_beats[i]++;
            if (rsp_tlast) rsp_last_at[i] = rsp_beats[i];
          end
        end
        if (prb_m_tvalid && m_phase != PH_RSP) m_flag = 1'b1;
        if (m_phase == PH_IDLE && |req_tvalid) begin
          m_owner = rr_expect(req_tvalid, m_last);
          m_gid   = m_owner;
          grant_log.push_back(m_owner);
          m_phase = PH_STIM;
        end else if (m_phase == PH_STIM && req_tvalid[g] && prb_s_tready && req_tlast[g]) begin
          m_phase = PH_RSP;
        end else if (m_phase == PH_RSP && prb_m_tvalid && rsp_tready[g] && prb_m_tlast) begin
          m_phase = PH_IDLE;
          m_last  = g;
          m_cnt   = m_cnt + 32'd1;
        end
      end
    end
  end

  // Requester and probe traffic generators (AXIS-compliant: valid holds until accepted)
  initial begin : driver
    bit hs_r[N];
    bit hs_m, s_last_hs;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) hs_r[i] = req_tvalid[i] && req_tready[i];
      hs_m      = prb_m_tvalid && prb_m_tready;
      s_last_hs = prb_s_tvalid && prb_s_tready && prb_s_tlast;
      @(posedge clk); #1;
      if (!rst_n) begin
        for (int i = 0; i < N; i++) begin
          r_active[i] = 1'b0; r_pkts_left[i] = 0;
        end
        req_tvalid = '0; req_tlast = '0; rsp_tready = '0; prb_s_tready = 1'b0;
        prb_m_tvalid = 1'b0; prb_m_tlast = 1'b0; p_active = 1'b0; stray_req = 1'b0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (hs_r[i]) begin
            if (req_tlast[i]) r_active[i] = 1'b0;
            else r_beat[i]++;
          end
          if (!r_active[i] && r_pkts_left[i] > 0) begin
            r_active[i] = 1'b1; r_pkts_left[i]--; r_beat[i] = 0;
            r_len[i] = (fixed_len > 0) ? fixed_len : int'($urandom_range(6, 1));
          end
          if (req_tvalid[i] && !hs_r[i]) begin
            req_tvalid[i] = 1'b1;
          end else if (r_active[i]) begin
            req_tvalid[i] = (int'($urandom_range(99)) < v_duty);
            req_tdata[i*DW +: DW] = rand_beat();
            req_tkeep[i*KW +: KW] = KW'($urandom);
            req_tlast[i] = (r_beat[i] == r_len[i] - 1);
          end else begin
            req_tvalid[i] = 1'b0; req_tlast[i] = 1'b0;
          end
          rsp_tready[i] = (int'($urandom_range(99)) < m_rdy_duty);
        end
        prb_s_tready = (int'($urandom_range(99)) < s_rdy_duty);
        if (hs_m) begin
          if (prb_m_tlast) p_active = 1'b0;
          else p_beat++;
        end
        if (s_last_hs) begin
          p_active = 1'b1; p_beat = 0;
          p_len = (rsp_fixed > 0) ? rsp_fixed : int'($urandom_range(5, 1));
        end
        if (stray_req) begin
          prb_m_tvalid = 1'b1; prb_m_tlast = 1'b0; prb_m_tdata = rand_beat(); stray_req = 1'b0;
        end else if (prb_m_tvalid && !hs_m && p_active) begin
          prb_m_tvalid = 1'b1;
        end else if (p_active) begin
          prb_m_tvalid = (int'($urandom_range(99)) < m_v_duty);
          prb_m_tdata  = rand_beat();
          prb_m_tkeep  = KW'($urandom);
          prb_m_tlast  = (p_beat == p_len - 1);
        end else begin
          prb_m_tvalid = 1'b0; prb_m_tlast = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int exp_order[4] = '{0, 1, 0, 1};
    repeat (3) @(posedge clk);
    #2;
    chk("pin_reset_grant_id", CW'(grant_id), CW'(0));
    chk("pin_reset_txn_cnt", CW'(txn_cnt), CW'(0));
    rst_n = 1'b1;

    // Single 10-beat exchange from requester 1
    fixed_len = 10; rsp_fixed = 10;
    r_pkts_left[1] = 1;
    wait_done("single", 200);
    chk("single_grant_id", CW'(grant_id), CW'(1));
    chk("single_txn_cnt", CW'(txn_cnt), CW'(1));
    chk("single_rsp_beats1", CW'(rsp_beats[1]), CW'(10));
    chk("single_rsp_tlast_beat", CW'(rsp_last_at[1]), CW'(10));
    chk("single_rsp_beats0", CW'(rsp_beats[0]), CW'(0));
    chk("single_busy_after", CW'(busy), CW'(1'b0));

    // Contention: both requesters hold tvalid for 4 exchanges
    grant_log.delete();
    fixed_len = 3; rsp_fixed = 2;
    r_pkts_left[0] = 2; r_pkts_left[1] = 2;
    wait_done("contention", 300);
    chk("contention_grants", CW'(grant_log.size()), CW'(4));
    for (int k = 0; k < 4 && k < grant_log.size(); k++) chk("contention_order", CW'(grant_log[k]), CW'(exp_order[k]));
    chk("contention_txn_cnt", CW'(txn_cnt), CW'(5));

    // Random traffic with 50% backpressure on both sides
    fixed_len = 0; rsp_fixed = 0;
    v_duty = 50; s_rdy_duty = 50; m_rdy_duty = 50; m_v_duty = 50;
    r_pkts_left[0] = 12; r_pkts_left[1] = 12;
    wait_done("random", 6000);
    chk("random_txn_cnt", CW'(txn_cnt), CW'(29));

    // Stray response beat while idle; flag must survive a good exchange
    v_duty = 100; s_rdy_duty = 100; m_rdy_duty = 100; m_v_duty = 100;
    stray_req = 1'b1;
    repeat (3) begin @(posedge clk); #2; end
    chk("stray_flag", CW'(rsp_unexpected), CW'(1'b1));
    r_pkts_left[0] = 1;
    wait_done("after_stray", 200);
    chk("stray_flag_sticky", CW'(rsp_unexpected), CW'(1'b1));
    chk("stray_txn_cnt", CW'(txn_cnt), CW'(30));

    // Asynchronous reset after 3 of 10 stimulus beats
    fixed_len = 10; rsp_fixed = 10;
    for (int i = 0; i < N; i++) req_beats[i] = 0;
    r_pkts_left[1] = 1;
    for (int n = 0; n < 100 && req_beats[1] < 3; n++) begin @(posedge clk); #2; end
    chk("midreq_beats", CW'(req_beats[1]), CW'(3));
    rst_n = 1'b0;
    #1;
    chk("midreq_async_handshake", CW'({req_tready, rsp_tvalid, prb_s_tvalid, prb_m_tready}), CW'(0));
    chk("midreq_async_status", CW'({busy, grant_id, rsp_unexpected}), CW'(0));
    chk("midreq_async_txn_cnt", CW'(txn_cnt), CW'(0));
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    grant_log.delete();
    fixed_len = 2; rsp_fixed = 2;
    r_pkts_left[0] = 1; r_pkts_left[1] = 1;
    wait_done("after_reset", 200);
    chk("after_reset_first_grant", CW'(grant_log.size() > 0 ? grant_log[0] : -1), CW'(0));
    chk("after_reset_txn_cnt", CW'(txn_cnt), CW'(2));

    // Counter wrap
    force dut.txn_cnt_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    @(posedge clk); #2;
    release dut.txn_cnt_q;
    @(posedge clk); #2;
    chk("wrap_preload", CW'(txn_cnt), CW'(32'hFFFF_FFFF));
    r_pkts_left[0] = 1;
    wait_done("wrap", 200);
    chk("wrap_txn_cnt", CW'(txn_cnt), CW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
